// File: rtl/slave_device.sv
// Memory-backed cross-bar slave: single-word read/write over a req/ack handshake,
// with reads returning data on a one-cycle resp pulse after ack.
`timescale 1ns/1ps
module slave_device #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 4
) (
  input  logic              slave_clk,
  input  logic              slave_rst_in,
  input  logic              slave_req,
  input  logic              slave_cmd,
  input  logic [ADDR_W-1:0] slave_addr,
  input  logic [DATA_W-1:0] slave_wdata,
  output logic              slave_ack,
  output logic              slave_resp,
  output logic [DATA_W-1:0] slave_rdata
);

  localparam int DEPTH = 2 ** MEM_AW;

  typedef enum logic [1:0] {IDLE, ACK, RESP} state_t;

  state_t              state_reg;
  logic                cmd_reg;
  logic [MEM_AW-1:0]   idx_reg;
  logic                ack_reg;
  logic                resp_reg;
  logic [DATA_W-1:0]   rdata_reg;
  logic [DATA_W-1:0]   mem_reg [DEPTH];

  logic [MEM_AW-1:0]   req_idx;
  logic                unused_addr_hi;

  // Upper address bits were already decoded by the cross-bar; the index wraps.
  assign req_idx        = slave_addr[MEM_AW-1:0];
  assign unused_addr_hi = ^slave_addr[ADDR_W-1:MEM_AW];

  always_ff @(posedge slave_clk or negedge slave_rst_in) begin
    if (!slave_rst_in) begin
      state_reg <= IDLE;
      cmd_reg   <= 1'b0;
      idx_reg   <= '0;
      ack_reg   <= 1'b0;
      resp_reg  <= 1'b0;
      rdata_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          resp_reg <= 1'b0;
          if (slave_req) begin
            cmd_reg   <= slave_cmd;
            idx_reg   <= req_idx;
            ack_reg   <= 1'b1;
            state_reg <= ACK;
            if (slave_cmd) begin
              mem_reg[req_idx] <= slave_wdata;
            end
          end
        end
        ACK: begin
          ack_reg <= 1'b0;
          if (cmd_reg) begin
            state_reg <= IDLE;
          end else begin
            rdata_reg <= mem_reg[idx_reg];
            resp_reg  <= 1'b1;
            state_reg <= RESP;
          end
        end
        RESP: begin
          resp_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          ack_reg   <= 1'b0;
          resp_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign slave_ack   = ack_reg;
  assign slave_resp  = resp_reg;
  assign slave_rdata = rdata_reg;

endmodule

// File: tb/tb_slave_device.sv
// Scoreboard bench for slave_device: directed scenarios plus random traffic
// checked against a word-array model and an issue-to-ack latency model.
`timescale 1ns/1ps
module tb_slave_device;

  logic        slave_clk;
  logic        slave_rst_in;
  logic        slave_req;
  logic        slave_cmd;
  logic [31:0] slave_addr;
  logic [31:0] slave_wdata;
  logic        slave_ack;
  logic        slave_resp;
  logic [31:0] slave_rdata;

  slave_device #(.DATA_W(32), .ADDR_W(32), .MEM_AW(4)) dut (
    .slave_clk   (slave_clk),
    .slave_rst_in(slave_rst_in),
    .slave_req   (slave_req),
    .slave_cmd   (slave_cmd),
    .slave_addr  (slave_addr),
    .slave_wdata (slave_wdata),
    .slave_ack   (slave_ack),
    .slave_resp  (slave_resp),
    .slave_rdata (slave_rdata)
  );

  initial slave_clk = 1'b0;
  always #5 slave_clk = ~slave_clk;

  typedef struct {
    bit          is_read;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          compared = 0;
  int          mismatched = 0;
  logic [31:0] model [16];
  int          prev_base = 1;

  logic        pend = 1'b0;
  logic [31:0] pend_data = '0;
  logic [31:0] held = '0;
  logic        prev_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per ack and checks the resp/rdata that follows.
  always @(negedge slave_clk) begin
    if (!slave_rst_in) begin
      exp_q.delete();
      pend     = 1'b0;
      held     = '0;
      prev_ack = 1'b0;
    end else begin
      if (pend) begin
        check("resp_pulse", 32'(slave_resp), 32'd1);
        check("read_data", slave_rdata, pend_data);
        held = pend_data;
        pend = 1'b0;
      end else begin
        if (slave_resp) check("resp_spurious", 32'(slave_resp), 32'd0);
        check("rdata_held", slave_rdata, held);
      end
      if (slave_ack) begin
        if (slave_resp) check("ack_resp_overlap", 32'(slave_resp), 32'd0);
        if (prev_ack) check("ack_width", 32'(prev_ack), 32'd0);
        if (exp_q.size() == 0) begin
          check("ack_unexpected", 32'(slave_ack), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.is_read) begin
            pend      = 1'b1;
            pend_data = mon_e.data;
          end
        end
      end
      prev_ack = slave_ack;
    end
  end

  // Issued at a falling edge; returns at the falling edge where ack is seen.
  task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d, input int gap);
    int  expw;
    int  n;
    bit  got;
    logic [3:0] idx;
    if (gap > 0) begin
      slave_req = 1'b0;
      repeat (gap) @(negedge slave_clk);
    end
    expw = prev_base - gap;
    if (expw < 1) expw = 1;
    idx = a[3:0];
    exp_q.push_back(exp_t'{is_read: !w, data: (w ? 32'h0 : model[idx])});
    if (w) model[idx] = d;
    slave_req   = 1'b1;
    slave_cmd   = w;
    slave_addr  = a;
    slave_wdata = d;
    got = 1'b0;
    n   = 0;
    for (int c = 1; c <= 10 && !got; c++) begin
      @(negedge slave_clk);
      if (slave_ack) begin
        got = 1'b1;
        n   = c;
      end
    end
    if (!got) begin
      compared++;
      mismatched++;
      $display("FAIL ack_timeout: no ack within 10 cycles, expected one after %0d (addr %h)", expw, a);
    end else begin
      check("ack_latency", 32'(n), 32'(expw));
    end
    prev_base = w ? 2 : 3;
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear before any clock edge.
  task automatic apply_reset();
    slave_rst_in = 1'b0;
    slave_req    = 1'b0;
    #1;
    check("rst_ack", 32'(slave_ack), 32'd0);
    check("rst_resp", 32'(slave_resp), 32'd0);
    check("rst_rdata", slave_rdata, 32'd0);
    for (int i = 0; i < 16; i++) model[i] = '0;
    prev_base = 1;
    @(posedge slave_clk);
    @(posedge slave_clk);
    #1 slave_rst_in = 1'b1;
    @(negedge slave_clk);
  endtask

  initial begin
    slave_rst_in = 1'b0;
    slave_req    = 1'b0;
    slave_cmd    = 1'b0;
    slave_addr   = '0;
    slave_wdata  = '0;
    #2;
    apply_reset();

    // Fresh memory reads zero
    issue(1'b0, 32'h1000_0005, 32'h0, 0);
    // Writes, then reads back (rdata held checked by monitor)
    issue(1'b1, 32'h1000_0001, 32'h0000_1111, 0);
    issue(1'b1, 32'h1000_0002, 32'h0000_2222, 1);
    issue(1'b1, 32'h1000_0004, 32'h0000_3333, 2);
    issue(1'b0, 32'h1000_0001, 32'h0, 0);
    issue(1'b0, 32'h1000_0002, 32'h0, 1);
    issue(1'b0, 32'h1000_0004, 32'h0, 3);
    // req held across a write then a read of the same word
    issue(1'b1, 32'h1000_0007, 32'hA5A5_5A5A, 0);
    issue(1'b0, 32'h1000_0007, 32'hFFFF_FFFF, 0);
    // Upper address bits alias onto the same index
    issue(1'b1, 32'h2000_0013, 32'hDEAD_BEEF, 0);
    issue(1'b0, 32'h1000_0003, 32'h0, 0);
    // Reset during ACK of a read
    issue(1'b0, 32'h1000_0001, 32'h0, 0);
    #2;
    apply_reset();
    issue(1'b0, 32'h1000_0001, 32'h0, 0);
    // Reset during RESP, after refilling a word
    issue(1'b1, 32'h1000_0001, 32'h1234_5678, 0);
    issue(1'b0, 32'h1000_0001, 32'h0, 0);
    @(negedge slave_clk);
    #2;
    apply_reset();
    issue(1'b0, 32'h1000_0001, 32'h0, 0);

    // Random traffic
    for (int t = 0; t < 200; t++) begin
      int gap;
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      issue(bit'($urandom_range(0, 1)), $urandom, $urandom, gap);
    end

    slave_req = 1'b0;
    repeat (5) @(negedge slave_clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
